sb_multiplane: RTL and testbench

//  Next-generation FPGA routing switch box: each of WIDTH tracks carries PLANES independent routing planes,
//  so one track can route N->W and E->S at once. Each plane picks one source side and drives any subset of
//  the other sides, combinationally or through a per-plane register for pipelined long routes.

---
 rtl/sb_pkg.sv | 29 ++
 rtl/sb_plane.sv | 34 +++
 rtl/sb_multiplane.sv | 127 ++++++++++++
 tb/tb_sb_multiplane.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types for the multi-plane switch box: side encoding, per-plane config field
// layout and the configuration FSM states.
package sb_pkg;

    localparam int PLANE_CFG_W = 8;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    // LSB first in the config stream: src, en, use_reg, dst_mask
    typedef struct packed {
        logic [3:0] dst_mask;
        logic       use_reg;
        logic       en;
        dir_e       src;
    } plane_cfg_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_ERR     = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/sb_plane.sv
// One routing plane of one track: picks a source side, optionally registers it,
// and drives the selected destination sides (never back onto its own source).
module sb_plane
    import sb_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  plane_cfg_t i_cfg,
    input  logic [3:0] i_side,   // bit0=N, bit1=E, bit2=S, bit3=W
    output logic [3:0] o_drive
);

    logic       w_sel;
    logic       w_val;
    logic [3:0] w_src_onehot;
    logic       r_q;

    assign w_sel = i_side[i_cfg.src];

    // Samples every cycle regardless of use_reg, so switching to registered mode
    // presents whatever the previous source selection captured.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_sel;
        end
    end

    assign w_val        = i_cfg.use_reg ? r_q : w_sel;
    assign w_src_onehot = 4'b0001 << i_cfg.src;
    assign o_drive      = {4{i_cfg.en & w_val}} & i_cfg.dst_mask & ~w_src_onehot;

endmodule

// File: rtl/sb_multiplane.sv
// Multi-plane switch box: double-buffered config (serial shadow chain + atomic commit
// into the active register) driving WIDTH x PLANES routing planes, wired-OR per side.
module sb_multiplane
    import sb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int PLANES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] north_in,
    input  logic [WIDTH-1:0] east_in,
    input  logic [WIDTH-1:0] south_in,
    input  logic [WIDTH-1:0] west_in,
    output logic [WIDTH-1:0] north_out,
    output logic [WIDTH-1:0] east_out,
    output logic [WIDTH-1:0] south_out,
    output logic [WIDTH-1:0] west_out,
    input  logic             config_data_in,
    input  logic             config_en,
    input  logic             config_commit,
    output logic             config_data_out,
    output logic             config_ready,
    output logic             config_err,
    output cfg_state_e       dbg_state
);

    localparam int CFG_BITS = WIDTH * PLANES * PLANE_CFG_W;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    cfg_state_e          r_state;
    cfg_state_e          w_state_nxt;
    logic                w_load;
    logic [3:0]          w_drive [WIDTH*PLANES];
    logic [3:0]          w_trk   [WIDTH];

    // Commit is judged on the pre-shift state; a same-cycle shift then counts as bit 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY, ST_FILLING: begin
                if (config_commit) begin
                    w_state_nxt = ST_ERR;
                    w_cnt_nxt   = '0;
                end else if (config_en) begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = (r_cnt + CNT_ONE == CNT_FULL) ? ST_FULL : ST_FILLING;
                end
            end
            ST_FULL: begin
                if (config_commit) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = config_en ? CNT_ONE : '0;
                    w_state_nxt = config_en ? ST_FILLING : ST_EMPTY;
                end
            end
            ST_ERR: begin
                w_cnt_nxt = '0;
                if (config_commit) begin
                    w_cnt_nxt   = config_en ? CNT_ONE : '0;
                    w_state_nxt = config_en ? ST_FILLING : ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= ST_EMPTY;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (config_en) begin
                r_shadow <= {r_shadow[CFG_BITS-2:0], config_data_in};
            end
            if (w_load) begin
                r_active <= r_shadow;
            end
        end
    end

    assign config_data_out = r_shadow[CFG_BITS-1];
    assign config_ready    = (r_state == ST_FULL);
    assign config_err      = (r_state == ST_ERR);
    assign dbg_state       = r_state;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_trk
        for (genvar gp = 0; gp < PLANES; gp++) begin : g_pl
            sb_plane u_plane (
                .clk     (clk),
                .nrst    (nrst),
                .i_cfg   (plane_cfg_t'(r_active[(gi*PLANES+gp)*PLANE_CFG_W +: PLANE_CFG_W])),
                .i_side  ({west_in[gi], south_in[gi], east_in[gi], north_in[gi]}),
                .o_drive (w_drive[gi*PLANES+gp])
            );
        end
        assign north_out[gi] = w_trk[gi][0];
        assign east_out[gi]  = w_trk[gi][1];
        assign south_out[gi] = w_trk[gi][2];
        assign west_out[gi]  = w_trk[gi][3];
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_trk[i] = 4'b0000;
            for (int p = 0; p < PLANES; p++) begin
                w_trk[i] = w_trk[i] | w_drive[i*PLANES+p];
            end
        end
    end

endmodule

// File: tb/tb_sb_multiplane.sv
// Randomised bench for sb_multiplane: a behavioural model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares.
module tb_sb_multiplane;
    import sb_pkg::*;

    localparam int W   = 32;
    localparam int P   = 2;
    localparam int CFG = W * P * 8;
    localparam int EW  = 4 * W + 5;

    logic         clk = 1'b0;
    logic         nrst;
    logic [W-1:0] n_in, e_in, s_in, w_in;
    logic [W-1:0] n_out, e_out, s_out, w_out;
    logic         cdi, cen, ccm;
    logic         cdo, crdy, cerr;
    cfg_state_e   dbg;

    sb_multiplane #(.WIDTH(W), .PLANES(P)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .north_in        (n_in),
        .east_in         (e_in),
        .south_in        (s_in),
        .west_in         (w_in),
        .north_out       (n_out),
        .east_out        (e_out),
        .south_out       (s_out),
        .west_out        (w_out),
        .config_data_in  (cdi),
        .config_en       (cen),
        .config_commit   (ccm),
        .config_data_out (cdo),
        .config_ready    (crdy),
        .config_err      (cerr),
        .dbg_state       (dbg)
    );

    always #5 clk = ~clk;

    // behavioural model
    logic [CFG-1:0] m_shadow, m_active, cfg;
    int             m_cnt;
    bit             m_err;
    bit             m_q [W][P];

    logic [EW-1:0]  exp_q [$];
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic logic side_bit(input logic [1:0] s, input int i);
        case (s)
            2'd0:    return n_in[i];
            2'd1:    return e_in[i];
            2'd2:    return s_in[i];
            default: return w_in[i];
        endcase
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_cnt    = 0;
        m_err    = 0;
        for (int i = 0; i < W; i++)
            for (int p = 0; p < P; p++)
                m_q[i][p] = 0;
    endtask

    // Clock edge: inputs still hold the values applied during the finished cycle.
    task automatic model_edge();
        logic [7:0] f;
        if (!nrst) begin
            model_reset();
        end else begin
            for (int i = 0; i < W; i++)
                for (int p = 0; p < P; p++) begin
                    f = m_active[(i*P+p)*8 +: 8];
                    m_q[i][p] = side_bit(f[1:0], i);
                end
            if (ccm) begin
                if (m_err) m_err = 0;
                else if (m_cnt == CFG) m_active = m_shadow;
                else m_err = 1;
                m_cnt = 0;
            end
            if (cen) begin
                m_shadow = {m_shadow[CFG-2:0], cdi};
                if (!m_err && m_cnt < CFG) m_cnt++;
            end
        end
    endtask

    function automatic logic [EW-1:0] expected();
        logic [W-1:0] o [4];
        logic [7:0]   f;
        logic         v;
        logic [1:0]   st;
        for (int s = 0; s < 4; s++) o[s] = '0;
        for (int i = 0; i < W; i++)
            for (int p = 0; p < P; p++) begin
                f = m_active[(i*P+p)*8 +: 8];
                v = f[3] ? m_q[i][p] : side_bit(f[1:0], i);
                for (int s = 0; s < 4; s++)
                    if (f[2] && f[4+s] && s != int'(f[1:0]))
                        o[s][i] = o[s][i] | v;
            end
        if (m_err)           st = ST_ERR;
        else if (m_cnt == 0) st = ST_EMPTY;
        else if (m_cnt == CFG) st = ST_FULL;
        else                 st = ST_FILLING;
        return {o[0], o[1], o[2], o[3], m_shadow[CFG-1], (!m_err && m_cnt == CFG), m_err, st};
    endfunction

    task automatic drive_rst(input logic rst_n, input logic en, input logic din, input logic cm);
        @(posedge clk);
        model_edge();
        #1;
        nrst = rst_n;
        cen  = en;
        cdi  = din;
        ccm  = cm;
        n_in = $urandom;
        e_in = $urandom;
        s_in = $urandom;
        w_in = $urandom;
        if (!rst_n) model_reset();
        exp_q.push_back(expected());
    endtask

    task automatic drive(input logic en, input logic din, input logic cm);
        drive_rst(1'b1, en, din, cm);
    endtask

    task automatic set_field(input int i, input int p, input logic [7:0] f);
        cfg[(i*P+p)*8 +: 8] = f;
    endtask

    task automatic shift_cfg();
        for (int k = CFG - 1; k >= 0; k--) drive(1'b1, cfg[k], 1'b0);
    endtask

    task automatic load_cfg(input int run);
        shift_cfg();
        drive(1'b0, 1'b0, 1'b1);
        repeat (run) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_cfg();
        for (int k = 0; k < CFG; k += 32) cfg[k +: 32] = $urandom;
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {n_out, e_out, s_out, w_out, cdo, crdy, cerr, dbg};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t actual=%h expected=%h", $time, a, e);
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: bench did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        nrst = 1'b0;
        cen  = 1'b0;
        cdi  = 1'b0;
        ccm  = 1'b0;
        n_in = '0;
        e_in = '0;
        s_in = '0;
        w_in = '0;
        model_reset();

        repeat (4) drive_rst(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 1'b0, 1'b0);

        // track0: plane0 N->W, plane1 E->S
        cfg = '0;
        set_field(0, 0, {4'b1000, 1'b0, 1'b1, 2'd0});
        set_field(0, 1, {4'b0100, 1'b0, 1'b1, 2'd1});
        load_cfg(20);

        // plane0 registered
        set_field(0, 0, {4'b1000, 1'b1, 1'b1, 2'd0});
        load_cfg(20);

        // plane0 targets only its own source side: no U-turn
        set_field(0, 0, {4'b0001, 1'b0, 1'b1, 2'd0});
        load_cfg(20);

        repeat (2) begin
            rand_cfg();
            load_cfg(40);
        end

        // premature commit, then a clearing commit
        rand_cfg();
        for (int k = CFG - 1; k >= 1; k--) drive(1'b1, cfg[k], 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        // chain overshoot: data_out replays the stream CFG cycles later
        for (int k = 0; k < 2 * CFG; k++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        repeat (30) drive(1'b0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a shift
        for (int k = 0; k < 100; k++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        drive_rst(1'b0, 1'b1, 1'b1, 1'b0);
        drive_rst(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 1'b0);

        // commit with a simultaneous shift from FULL
        rand_cfg();
        shift_cfg();
        drive(1'b1, 1'b1, 1'b1);
        repeat (30) drive(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
